system_arb_dut: RTL and testbench



---
 rtl/system_arb_pkg.sv | 30 +++
 rtl/system_arb_dut_fifo.sv | 62 ++++++
 rtl/system_arb_dut.sv | 206 ++++++++++++++++++++
 tb/tb_system_arb_dut.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/system_arb_pkg.sv
// -----------------------------------------------------------------------------
// system_arb_pkg
// Shared types and limits for the multi-channel stream arbiter:
//   arb_mode_e   - merge policy (round-robin or fixed priority, ch0 highest)
//   lock_state_e - packet-lock state of the output merge
//   beat_t       - {data, last} beat at the default 32-bit payload width
//   MAX_CH / MIN_FIFO_DEPTH - legal parameter bounds
// -----------------------------------------------------------------------------
package system_arb_pkg;

  typedef enum logic {
    ARB_RR,
    ARB_PRIO
  } arb_mode_e;

  typedef enum logic {
    IDLE,
    LOCKED
  } lock_state_e;

  localparam int MAX_CH         = 8;
  localparam int MIN_FIFO_DEPTH = 2;
  localparam int BEAT_DATA_W    = 32;

  typedef struct packed {
    logic [BEAT_DATA_W-1:0] data;
    logic                   last;
  } beat_t;

endpackage

// File: rtl/system_arb_dut_fifo.sv
// -----------------------------------------------------------------------------
// sys_chan_fifo
// Per-channel synchronous FIFO. The head entry is read combinationally so the
// arbiter can pop and load the output register in the same cycle.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata     - write request and data (ignored while full)
//   pop             - read request (ignored while empty)
//   rdata           - current head entry
//   full, empty     - occupancy status derived from the pointer registers
// -----------------------------------------------------------------------------
module sys_chan_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Pointers carry one extra MSB: equal low bits with differing MSBs means full.
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/system_arb_dut.sv
// -----------------------------------------------------------------------------
// system_arb_dut
// Merges NUM_CH valid/ready input streams, each buffered in its own FIFO, onto
// one registered output stream tagged with the source channel. Round-robin or
// fixed-priority arbitration, with optional packet locking.
// Ports:
//   clk, rst_n                   - clock, asynchronous active-low reset
//   in_valid/in_ready/in_last    - per-channel handshake and end-of-packet
//   in_data                      - channel i at [i*DATA_W +: DATA_W]
//   out_valid/out_ready          - output handshake
//   out_data/out_last/out_ch     - output beat and its source channel
//   fifo_full                    - per-channel FIFO full status
// -----------------------------------------------------------------------------
module system_arb_dut
  import system_arb_pkg::*;
#(
  parameter int        NUM_CH     = 3,
  parameter int        DATA_W     = 32,
  parameter int        FIFO_DEPTH = 4,
  parameter arb_mode_e ARB_MODE   = ARB_RR,
  parameter bit        PKT_LOCK   = 1'b0,
  localparam int       CH_W       = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [CH_W-1:0]          out_ch,
  output logic [NUM_CH-1:0]        fifo_full
);

  localparam int BEAT_W = DATA_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } chan_beat_t;

  if (NUM_CH < 2 || NUM_CH > MAX_CH) begin : g_bad_num_ch
    $error("system_arb_dut: NUM_CH out of range");
  end
  if (FIFO_DEPTH < MIN_FIFO_DEPTH || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("system_arb_dut: FIFO_DEPTH must be a power of two >= 2");
  end

  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] fifo_full_w;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  chan_beat_t        head [NUM_CH];

  logic              out_free;
  logic [NUM_CH-1:0] cand_mask;
  logic              grant_valid;
  logic [CH_W-1:0]   grant_idx;

  lock_state_e       lock_state_q, lock_state_d;
  logic [CH_W-1:0]   lock_ch_q, lock_ch_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;

  // ---------------------------------------------------------------------------
  // Channel FIFOs
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [BEAT_W-1:0] head_raw;

    // in_ready reflects registered occupancy only; no same-cycle pop bypass.
    assign push[gi] = in_valid[gi] && !fifo_full_w[gi];
    assign pop[gi]  = out_free && grant_valid && (grant_idx == CH_W'(gi));

    sys_chan_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (BEAT_W)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[gi]),
      .wdata ({in_data[gi*DATA_W +: DATA_W], in_last[gi]}),
      .pop   (pop[gi]),
      .rdata (head_raw),
      .full  (fifo_full_w[gi]),
      .empty (fifo_empty[gi])
    );

    assign head[gi] = chan_beat_t'(head_raw);
  end

  assign in_ready  = ~fifo_full_w;
  assign fifo_full = fifo_full_w;

  assign out_free = !out_valid_q || out_ready;

  // ---------------------------------------------------------------------------
  // Lock FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_state_q <= IDLE;
      lock_ch_q    <= '0;
    end else begin
      lock_state_q <= lock_state_d;
      lock_ch_q    <= lock_ch_d;
    end
  end

  // Lock FSM: next state. Only beats actually loaded into the output register
  // move the FSM; a last=0 beat locks onto its channel, a last=1 beat unlocks.
  always_comb begin
    lock_state_d = lock_state_q;
    lock_ch_d    = lock_ch_q;
    if (PKT_LOCK && out_free && grant_valid) begin
      if (head[grant_idx].last) begin
        lock_state_d = IDLE;
      end else begin
        lock_state_d = LOCKED;
        lock_ch_d    = grant_idx;
      end
    end
  end

  // Lock FSM: output. While locked only the owning channel may compete, so an
  // empty owner produces a bubble instead of a switch.
  always_comb begin
    cand_mask = ~fifo_empty;
    if (lock_state_q == LOCKED) begin
      cand_mask = '0;
      cand_mask[lock_ch_q] = !fifo_empty[lock_ch_q];
    end
  end

  // ---------------------------------------------------------------------------
  // Arbiter
  // ---------------------------------------------------------------------------
  always_comb begin : arb_comb
    int idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int off = 0; off < NUM_CH; off++) begin
      if (ARB_MODE == ARB_RR) idx = (int'(rr_ptr_q) + off) % NUM_CH;
      else                    idx = off;
      if (!grant_valid && cand_mask[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = CH_W'(idx);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (ARB_MODE == ARB_RR && out_free && grant_valid) begin
      rr_ptr_d = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Output register: loads only when free, so payload holds during a stall.
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
    if (out_free) begin
      out_valid_d = grant_valid;
      if (grant_valid) begin
        out_data_d = head[grant_idx].data;
        out_last_d = head[grant_idx].last;
        out_ch_d   = grant_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_system_arb_dut.sv
// -----------------------------------------------------------------------------
// tb_system_arb_dut
// Three DUT instances share clk/rst_n:
//   [0] round-robin, no lock   [1] fixed priority, no lock   [2] round-robin, lock
// Inputs change and outputs are checked on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_system_arb_dut;
  import system_arb_pkg::*;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  in_valid  [NI];
  logic [2:0]  in_ready  [NI];
  logic [95:0] in_data   [NI];
  logic [2:0]  in_last   [NI];
  logic        out_valid [NI];
  logic        out_ready [NI];
  logic [31:0] out_data  [NI];
  logic        out_last  [NI];
  logic [1:0]  out_ch    [NI];
  logic [2:0]  fifo_full [NI];

  int n_cmp = 0;
  int n_bad = 0;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    system_arb_dut #(
      .NUM_CH     (3),
      .DATA_W     (32),
      .FIFO_DEPTH (4),
      .ARB_MODE   (gi == 1 ? ARB_PRIO : ARB_RR),
      .PKT_LOCK   (gi == 2 ? 1'b1 : 1'b0)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[gi]),
      .in_ready  (in_ready[gi]),
      .in_data   (in_data[gi]),
      .in_last   (in_last[gi]),
      .out_valid (out_valid[gi]),
      .out_ready (out_ready[gi]),
      .out_data  (out_data[gi]),
      .out_last  (out_last[gi]),
      .out_ch    (out_ch[gi]),
      .fifo_full (fifo_full[gi])
    );
  end

  task automatic clear_inputs();
    for (int i = 0; i < NI; i++) begin
      in_valid[i]  = '0;
      in_data[i]   = '0;
      in_last[i]   = '0;
      out_ready[i] = 1'b0;
    end
  endtask

  task automatic reset_all();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      n_cmp++; if (out_valid[i] !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid[%0d]: got %b want 0", i, out_valid[i]); end
      n_cmp++; if (in_ready[i] !== 3'b111) begin n_bad++; $display("FAIL rst_in_ready[%0d]: got %b want 111", i, in_ready[i]); end
      n_cmp++; if (fifo_full[i] !== 3'b000) begin n_bad++; $display("FAIL rst_fifo_full[%0d]: got %b want 000", i, fifo_full[i]); end
      n_cmp++; if (out_data[i] !== 32'h0 || out_last[i] !== 1'b0 || out_ch[i] !== 2'd0) begin
        n_bad++; $display("FAIL rst_out_beat[%0d]: got data=%h last=%b ch=%0d want 0/0/0", i, out_data[i], out_last[i], out_ch[i]);
      end
      $display("reset check inst %0d done", i);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_rr_fairness();
    logic [31:0] ch_val [3];
    int exp_ch;
    ch_val[0] = 32'h0000_00C0;
    ch_val[1] = 32'h1111_0001;
    ch_val[2] = 32'h2222_0002;
    out_ready[0] = 1'b1;
    in_valid[0]  = 3'b111;
    in_last[0]   = 3'b111;
    in_data[0]   = {ch_val[2], ch_val[1], ch_val[0]};
    @(negedge clk);
    n_cmp++; if (out_valid[0] !== 1'b0) begin n_bad++; $display("FAIL rr_latency: got out_valid=%b want 0", out_valid[0]); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_ch = k % 3;
      n_cmp++; if (out_valid[0] !== 1'b1 || out_ch[0] !== 2'(exp_ch) || out_data[0] !== ch_val[exp_ch]) begin
        n_bad++; $display("FAIL rr_beat[%0d]: got v=%b ch=%0d data=%h want v=1 ch=%0d data=%h", k, out_valid[0], out_ch[0], out_data[0], exp_ch, ch_val[exp_ch]);
      end
      $display("rr beat %0d: ch=%0d data=%h", k, out_ch[0], out_data[0]);
    end
    in_valid[0] = '0;
  endtask

  task automatic test_prio();
    logic [1:0]  exp_ch [8];
    logic [31:0] exp_d  [8];
    for (int k = 0; k < 4; k++) begin
      exp_ch[k]   = 2'd0; exp_d[k]   = 32'h10 + 32'(k);
      exp_ch[k+4] = 2'd2; exp_d[k+4] = 32'h20 + 32'(k);
    end
    out_ready[1] = 1'b0;
    for (int b = 0; b < 4; b++) begin
      in_valid[1] = 3'b101;
      in_last[1]  = 3'b101;
      in_data[1][31:0]  = 32'h10 + 32'(b);
      in_data[1][95:64] = 32'h20 + 32'(b);
      @(negedge clk);
    end
    in_valid[1] = '0;
    // ch0 beat 0 sits in the output register, so only ch2 holds four entries
    n_cmp++; if (fifo_full[1] !== 3'b100) begin n_bad++; $display("FAIL prio_full: got %b want 100", fifo_full[1]); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (out_valid[1] !== 1'b1 || out_ch[1] !== exp_ch[k] || out_data[1] !== exp_d[k]) begin
        n_bad++; $display("FAIL prio_beat[%0d]: got v=%b ch=%0d data=%h want v=1 ch=%0d data=%h", k, out_valid[1], out_ch[1], out_data[1], exp_ch[k], exp_d[k]);
      end
      $display("prio beat %0d: ch=%0d data=%h", k, out_ch[1], out_data[1]);
      out_ready[1] = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (out_valid[1] !== 1'b0) begin n_bad++; $display("FAIL prio_drained: got out_valid=%b want 0", out_valid[1]); end
  endtask

  task automatic test_backpressure();
    out_ready[0] = 1'b0;
    for (int b = 0; b < 5; b++) begin
      in_valid[0] = 3'b010;
      in_last[0]  = 3'b010;
      in_data[0][63:32] = 32'hA0 + 32'(b);
      @(negedge clk);
      if (b == 3) begin
        n_cmp++; if (fifo_full[0] !== 3'b000) begin n_bad++; $display("FAIL bp_not_full_yet: got %b want 000", fifo_full[0]); end
      end
    end
    // A5 is offered but must not be accepted while full
    in_data[0][63:32] = 32'hA5;
    n_cmp++; if (fifo_full[0] !== 3'b010) begin n_bad++; $display("FAIL bp_full: got %b want 010", fifo_full[0]); end
    n_cmp++; if (in_ready[0] !== 3'b101) begin n_bad++; $display("FAIL bp_in_ready: got %b want 101", in_ready[0]); end
    n_cmp++; if (out_valid[0] !== 1'b1 || out_data[0] !== 32'hA0 || out_ch[0] !== 2'd1) begin
      n_bad++; $display("FAIL bp_out_reg: got v=%b data=%h ch=%0d want v=1 data=a0 ch=1", out_valid[0], out_data[0], out_ch[0]);
    end
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      n_cmp++; if (out_data[0] !== 32'hA0 || out_valid[0] !== 1'b1) begin
        n_bad++; $display("FAIL bp_stall[%0d]: got v=%b data=%h want v=1 data=a0", s, out_valid[0], out_data[0]);
      end
    end
    in_valid[0] = '0;
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (out_valid[0] !== 1'b1 || out_data[0] !== 32'hA0 + 32'(k) || out_ch[0] !== 2'd1) begin
        n_bad++; $display("FAIL bp_order[%0d]: got v=%b data=%h ch=%0d want v=1 data=%h ch=1", k, out_valid[0], out_data[0], out_ch[0], 32'hA0 + 32'(k));
      end
      $display("bp beat %0d: data=%h", k, out_data[0]);
      out_ready[0] = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (out_valid[0] !== 1'b0 || in_ready[0] !== 3'b111) begin
      n_bad++; $display("FAIL bp_drained: got v=%b in_ready=%b want v=0 in_ready=111", out_valid[0], in_ready[0]);
    end
  endtask

  task automatic test_pkt_lock();
    out_ready[2] = 1'b1;
    in_valid[2] = 3'b011;
    in_last[2]  = 3'b010;
    in_data[2][31:0]  = 32'hB0;
    in_data[2][63:32] = 32'h1111;
    @(negedge clk);
    n_cmp++; if (out_valid[2] !== 1'b0) begin n_bad++; $display("FAIL lock_latency: got v=%b want 0", out_valid[2]); end
    in_data[2][31:0] = 32'hB1;
    @(negedge clk);
    n_cmp++; if (out_valid[2] !== 1'b1 || out_ch[2] !== 2'd0 || out_data[2] !== 32'hB0 || out_last[2] !== 1'b0) begin
      n_bad++; $display("FAIL lock_b0: got v=%b ch=%0d data=%h last=%b want 1/0/b0/0", out_valid[2], out_ch[2], out_data[2], out_last[2]);
    end
    in_valid[2][0] = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid[2] !== 1'b1 || out_ch[2] !== 2'd0 || out_data[2] !== 32'hB1) begin
      n_bad++; $display("FAIL lock_b1: got v=%b ch=%0d data=%h want 1/0/b1", out_valid[2], out_ch[2], out_data[2]);
    end
    @(negedge clk);
    n_cmp++; if (out_valid[2] !== 1'b0) begin n_bad++; $display("FAIL lock_gap0: got v=%b ch=%0d want v=0", out_valid[2], out_ch[2]); end
    in_valid[2][0] = 1'b1;
    in_last[2][0]  = 1'b1;
    in_data[2][31:0] = 32'hB2;
    @(negedge clk);
    n_cmp++; if (out_valid[2] !== 1'b0) begin n_bad++; $display("FAIL lock_gap1: got v=%b ch=%0d want v=0", out_valid[2], out_ch[2]); end
    in_valid[2][0] = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid[2] !== 1'b1 || out_ch[2] !== 2'd0 || out_data[2] !== 32'hB2 || out_last[2] !== 1'b1) begin
      n_bad++; $display("FAIL lock_b2: got v=%b ch=%0d data=%h last=%b want 1/0/b2/1", out_valid[2], out_ch[2], out_data[2], out_last[2]);
    end
    @(negedge clk);
    n_cmp++; if (out_valid[2] !== 1'b1 || out_ch[2] !== 2'd1 || out_data[2] !== 32'h1111) begin
      n_bad++; $display("FAIL lock_release: got v=%b ch=%0d data=%h want 1/1/1111", out_valid[2], out_ch[2], out_data[2]);
    end
    $display("pkt lock: channel %0d granted after packet end", out_ch[2]);
    in_valid[2] = '0;
  endtask

  task automatic test_reset_mid_packet();
    reset_all();
    out_ready[2] = 1'b0;
    for (int b = 0; b < 4; b++) begin
      in_valid[2] = 3'b010;
      in_last[2]  = 3'b000;
      in_data[2][63:32] = 32'hD0 + 32'(b);
      @(negedge clk);
    end
    in_valid[2] = '0;
    n_cmp++; if (out_valid[2] !== 1'b1 || out_ch[2] !== 2'd1 || out_data[2] !== 32'hD0) begin
      n_bad++; $display("FAIL mid_setup: got v=%b ch=%0d data=%h want 1/1/d0", out_valid[2], out_ch[2], out_data[2]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid[2] !== 1'b0 || in_ready[2] !== 3'b111 || fifo_full[2] !== 3'b000) begin
      n_bad++; $display("FAIL mid_async_rst: got v=%b in_ready=%b full=%b want 0/111/000", out_valid[2], in_ready[2], fifo_full[2]);
    end
    n_cmp++; if (out_data[2] !== 32'h0 || out_ch[2] !== 2'd0 || out_last[2] !== 1'b0) begin
      n_bad++; $display("FAIL mid_rst_beat: got data=%h ch=%0d last=%b want 0/0/0", out_data[2], out_ch[2], out_last[2]);
    end
    @(negedge clk);
    in_valid[2] = 3'b011;
    in_last[2]  = 3'b011;
    in_data[2][31:0]  = 32'hE0;
    in_data[2][63:32] = 32'hE1;
    out_ready[2] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid[2] !== 1'b0) begin n_bad++; $display("FAIL mid_discard: got v=%b ch=%0d data=%h want v=0", out_valid[2], out_ch[2], out_data[2]); end
    @(negedge clk);
    n_cmp++; if (out_valid[2] !== 1'b1 || out_ch[2] !== 2'd0 || out_data[2] !== 32'hE0) begin
      n_bad++; $display("FAIL mid_first_grant: got v=%b ch=%0d data=%h want 1/0/e0", out_valid[2], out_ch[2], out_data[2]);
    end
    $display("post-reset first grant: ch=%0d data=%h", out_ch[2], out_data[2]);
    in_valid[2] = '0;
  endtask

  initial begin
    test_reset();
    test_rr_fairness();
    reset_all();
    test_prio();
    reset_all();
    test_backpressure();
    reset_all();
    test_pkt_lock();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
